// File: rtl/keypad_event_ctrl_pkg.sv
// Shared types for the keypad event controller.
// KEYPAD_RELEASE_EVT_EN widens FIFO entries to carry the release flag.
package keypad_pkg;

  localparam int KP_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } kp_state_t;

  typedef struct packed {
    logic                 is_release;
    logic [KP_CODE_W-1:0] code;
  } kp_event_t;

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int KP_ENTRY_W = KP_CODE_W + 1;
`else
  localparam int KP_ENTRY_W = KP_CODE_W;
`endif

endpackage

// File: rtl/keypad_event_ctrl_if.sv
// Host-side event handshake: valid/ready plus the head event fields and queue level.
interface keypad_event_ctrl_if
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) ();

  logic                        ev_valid;
  logic                        ev_ready;
  logic [KP_CODE_W-1:0]        ev_code;
  logic                        ev_release;
  logic [$clog2(FIFO_DEPTH):0] ev_level;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_release,
    output ev_level,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_release,
    input  ev_level,
    output ev_ready
  );

endinterface

// File: rtl/keypad_event_ctrl_fifo.sv
// Show-ahead event FIFO with a separate level counter and drop detection.
module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Storage is not reset, so the head is forced to zero whenever nothing is queued.
  assign valid_o = !empty;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/keypad_event_ctrl.sv
// Debounces the keypad scanner stream into press (and optionally release) events.
// Define KEYPAD_RELEASE_EVT_EN to queue release events as well as presses.
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KP_CODE_W-1:0] key_code,
  input  logic                 key_valid,
  keypad_event_ctrl_if.master  ev,
  output logic                 overflow,
  input  logic                 clear_ovf
);

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  kp_state_t             state_q, state_d;
  logic [KP_CODE_W-1:0]  cur_code_q, cur_code_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            cnt_inc;
  logic                  at_limit;
  logic                  push;
  kp_event_t             push_ev;
  logic                  drop;
  logic                  ovf_q, ovf_d;
  logic [KP_ENTRY_W-1:0] fifo_wdata;
  logic [KP_ENTRY_W-1:0] fifo_head;

  assign cnt_inc  = cnt_q + 8'd1;
  assign at_limit = (cnt_inc == 8'(DEBOUNCE_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_code_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Only one key is tracked; a new code during release debounce is a roll-over.
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_ev    = '0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          cur_code_d = key_code;
          cnt_d      = 8'd1;
          state_d    = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (key_valid && (key_code == cur_code_q)) begin
          cnt_d = cnt_inc;
          if (at_limit) begin
            push    = 1'b1;
            push_ev = '{is_release: 1'b0, code: cur_code_q};
            state_d = HELD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!key_valid) begin
          cnt_d   = 8'd1;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (!key_valid) begin
          cnt_d = cnt_inc;
          if (at_limit) begin
            push    = REL_EN;
            push_ev = '{is_release: 1'b1, code: cur_code_q};
            state_d = IDLE;
          end
        end else if (key_code == cur_code_q) begin
          state_d = HELD;
        end else begin
          push       = REL_EN;
          push_ev    = '{is_release: 1'b1, code: cur_code_q};
          cur_code_d = key_code;
          cnt_d      = 8'd1;
          state_d    = DB_PRESS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as a clear request keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  assign overflow = ovf_q;

`ifdef KEYPAD_RELEASE_EVT_EN
  assign fifo_wdata    = push_ev;
  assign ev.ev_code    = fifo_head[KP_CODE_W-1:0];
  assign ev.ev_release = fifo_head[KP_CODE_W];
`else
  logic unused_rel;
  assign unused_rel    = push_ev.is_release;
  assign fifo_wdata    = push_ev.code;
  assign ev.ev_code    = fifo_head;
  assign ev.ev_release = 1'b0;
`endif

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KP_ENTRY_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (fifo_wdata),
    .pop_i       (ev.ev_ready),
    .valid_o     (ev.ev_valid),
    .head_o      (fifo_head),
    .level_o     (ev.ev_level),
    .drop_o      (drop)
  );

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl; expectations follow KEYPAD_RELEASE_EVT_EN.
module tb_keypad_event_ctrl;
  import keypad_pkg::*;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       overflow;
  logic       clearOvf;
  int         testsRun  = 0;
  int         failCount = 0;

  keypad_event_ctrl_if #(.FIFO_DEPTH(DEPTH)) evIf ();

  keypad_event_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_code  (keyCode),
    .key_valid (keyValid),
    .ev        (evIf.master),
    .overflow  (overflow),
    .clear_ovf (clearOvf)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge, so each call covers n rising-edge samples.
  task automatic applyStimulus(input logic v, input logic [3:0] c, input int n);
    keyValid = v;
    keyCode  = c;
    repeat (n) @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic v, input logic [3:0] c,
                           input logic r);
    checkOutput({tag, " valid"},   32'(evIf.ev_valid),   32'(v));
    checkOutput({tag, " code"},    32'(evIf.ev_code),    32'(c));
    checkOutput({tag, " release"}, 32'(evIf.ev_release), 32'(r));
  endtask

  int rollCode [3];
  int rollRel  [3];
  int nRoll;

  initial begin
`ifdef KEYPAD_RELEASE_EVT_EN
    rollCode = '{3, 3, 7};
    rollRel  = '{0, 1, 0};
    nRoll    = 3;
`else
    rollCode = '{3, 7, 0};
    rollRel  = '{0, 0, 0};
    nRoll    = 2;
`endif
    reset         = 1'b1;
    keyValid      = 1'b0;
    keyCode       = 4'h0;
    clearOvf      = 1'b0;
    evIf.ev_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    checkHead("reset", 1'b0, 4'h0, 1'b0);
    checkOutput("reset level", 32'(evIf.ev_level), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset fsm", 32'(dut.state_q), 32'(IDLE));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Clean press of 5 with the host always ready.
    evIf.ev_ready = 1'b1;
    applyStimulus(1'b1, 4'h5, 3);
    checkOutput("press edge3 valid", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(1'b1, 4'h5, 1);
    checkHead("press edge4", 1'b1, 4'h5, 1'b0);
    checkOutput("press edge4 level", 32'(evIf.ev_level), 32'd1);
    applyStimulus(1'b1, 4'h5, 1);
    checkOutput("press popped valid", 32'(evIf.ev_valid), 32'd0);
    checkOutput("press popped level", 32'(evIf.ev_level), 32'd0);
    applyStimulus(1'b1, 4'h5, 5);
    applyStimulus(1'b0, 4'h5, 3);
    checkOutput("release edge3 valid", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(1'b0, 4'h5, 1);
    checkHead("release edge4", REL, REL ? 4'h5 : 4'h0, REL);
    applyStimulus(1'b0, 4'h5, 6);
    checkOutput("clean end valid", 32'(evIf.ev_valid), 32'd0);
    checkOutput("clean end fsm", 32'(dut.state_q), 32'(IDLE));

    // Bounce on A, then a stable press.
    evIf.ev_ready = 1'b0;
    applyStimulus(1'b1, 4'hA, 3);
    applyStimulus(1'b0, 4'hA, 1);
    checkOutput("bounce fsm", 32'(dut.state_q), 32'(IDLE));
    checkOutput("bounce valid", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(1'b1, 4'hA, 3);
    checkOutput("stable edge3 valid", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(1'b1, 4'hA, 1);
    checkHead("stable press", 1'b1, 4'hA, 1'b0);
    checkOutput("stable level", 32'(evIf.ev_level), 32'd1);
    applyStimulus(1'b0, 4'hA, 6);
    checkOutput("stable release level", 32'(evIf.ev_level), 32'(1 + int'(REL)));
    evIf.ev_ready = 1'b1;
    applyStimulus(1'b0, 4'h0, 2);
    checkOutput("bounce drained level", 32'(evIf.ev_level), 32'd0);
    evIf.ev_ready = 1'b0;

    // Five press/release pairs into a four-entry queue.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4'(k), 5);
      applyStimulus(1'b0, 4'(k), 5);
    end
    checkOutput("ovf level", 32'(evIf.ev_level), 32'd4);
    checkOutput("ovf flag", 32'(overflow), 32'd1);
    evIf.ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkHead($sformatf("ovf drain %0d", i), 1'b1,
                REL ? 4'(i / 2) : 4'(i), REL ? 1'(i % 2) : 1'b0);
      @(negedge clock);
    end
    evIf.ev_ready = 1'b0;
    checkOutput("ovf drained valid", 32'(evIf.ev_valid), 32'd0);
    checkOutput("ovf sticky", 32'(overflow), 32'd1);
    clearOvf = 1'b1;
    @(negedge clock);
    clearOvf = 1'b0;
    checkOutput("ovf cleared", 32'(overflow), 32'd0);

    // Fill to four, then pop on the exact edge that pushes the press of C.
    for (int k = 0; k < (REL ? 2 : 4); k++) begin
      applyStimulus(1'b1, 4'(8 + k), 5);
      applyStimulus(1'b0, 4'(8 + k), 5);
    end
    checkOutput("full level", 32'(evIf.ev_level), 32'd4);
    applyStimulus(1'b1, 4'hC, 3);
    evIf.ev_ready = 1'b1;
    applyStimulus(1'b1, 4'hC, 1);
    evIf.ev_ready = 1'b0;
    checkOutput("full pop overflow", 32'(overflow), 32'd0);
    checkOutput("full pop level", 32'(evIf.ev_level), 32'd4);
    checkHead("full pop head", 1'b1, REL ? 4'h8 : 4'h9, REL);
    evIf.ev_ready = 1'b1;
    applyStimulus(1'b1, 4'hC, 3);
    checkHead("full tail", 1'b1, 4'hC, 1'b0);
    checkOutput("full tail level", 32'(evIf.ev_level), 32'd1);
    applyStimulus(1'b1, 4'hC, 1);
    applyStimulus(1'b0, 4'hC, 6);
    checkOutput("full end level", 32'(evIf.ev_level), 32'd0);
    evIf.ev_ready = 1'b0;

    // Roll-over from 3 to 7 during release debounce.
    applyStimulus(1'b1, 4'h3, 6);
    applyStimulus(1'b0, 4'h3, 2);
    applyStimulus(1'b1, 4'h7, 6);
    checkOutput("roll level", 32'(evIf.ev_level), 32'(nRoll));
    evIf.ev_ready = 1'b1;
    for (int i = 0; i < nRoll; i++) begin
      checkHead($sformatf("roll ev %0d", i), 1'b1, 4'(rollCode[i]), 1'(rollRel[i]));
      @(negedge clock);
    end
    checkOutput("roll drained valid", 32'(evIf.ev_valid), 32'd0);
    applyStimulus(1'b0, 4'h7, 6);
    checkOutput("roll end level", 32'(evIf.ev_level), 32'd0);
    checkOutput("roll end fsm", 32'(dut.state_q), 32'(IDLE));
    evIf.ev_ready = 1'b0;

    // Asynchronous reset with two events queued and a press in debounce.
    for (int k = 0; k < (REL ? 1 : 2); k++) begin
      applyStimulus(1'b1, 4'(1 + k), 5);
      applyStimulus(1'b0, 4'(1 + k), 5);
    end
    checkOutput("pre-reset level", 32'(evIf.ev_level), 32'd2);
    applyStimulus(1'b1, 4'h6, 2);
    checkOutput("pre-reset fsm", 32'(dut.state_q), 32'(DB_PRESS));
    #2 reset = 1'b0;
    #1;
    checkHead("async reset", 1'b0, 4'h0, 1'b0);
    checkOutput("async reset level", 32'(evIf.ev_level), 32'd0);
    checkOutput("async reset fsm", 32'(dut.state_q), 32'(IDLE));
    keyValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0, 4'h6, 6);
    checkOutput("post-reset valid", 32'(evIf.ev_valid), 32'd0);
    checkOutput("post-reset level", 32'(evIf.ev_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/keypad_event_ctrl.md
# keypad_event_ctrl

- Sits between the Hex_Keypad_Grayhill_072 scanner and the host logic.
- Takes the scanner's raw `Code`/`Valid` stream and debounces it.
- Turns each stable press, and optionally each stable release, into one key event.
- Buffers events in a small FIFO and hands them to the host through a valid/ready handshake, so no keystroke is lost while the host is busy.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required to accept a press or release. Legal range 2..255.
- `FIFO_DEPTH`, default 4: event FIFO entries. Must be a power of 2, at least 2.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key_code`  in  4  scanner `Code` output.
- `key_valid`  in  1  scanner `Valid` output; a key is currently decoded.
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ready`  in  1  host accepts the head event.
- `ev_code`  out  4  key code of the head event.
- `ev_release`  out  1  head event is a release (0 = press).
- `ev_level`  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- `overflow`  out  1  sticky flag: an event was dropped because the FIFO was full.
- `clear_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Reset values: FSM in IDLE; FIFO empty; `ev_valid`=0, `ev_code`=0, `ev_release`=0, `ev_level`=0, `overflow`=0.
- FSM states:
  - IDLE:
    - `key_valid`=1: latch `key_code` into `cur_code`, set cnt=1, go to DB_PRESS.
  - DB_PRESS:
    - `key_valid`=1 and `key_code`==`cur_code`: cnt++.
    - Reaching cnt==DEBOUNCE_CYCLES: push {press, `cur_code`} and go to HELD.
    - `key_valid`=0 or a different code: return to IDLE with no event.
  - HELD:
    - `key_valid`=0: cnt=1, go to DB_RELEASE.
    - `key_valid`=1 with a different code is ignored; only one key is tracked at a time.
  - DB_RELEASE:
    - `key_valid`=0: cnt++.
    - Reaching cnt==DEBOUNCE_CYCLES: push {release, `cur_code`} (see Configuration) and go to IDLE.
    - `key_valid`=1 with `cur_code`: return to HELD with no event; this is a bounce.
    - `key_valid`=1 with a different code: treated as a release of the held key followed by a new press. Push the release immediately, latch the new code, cnt=1, go to DB_PRESS.
- Counter width is 8 bits; it is never compared beyond DEBOUNCE_CYCLES, so it cannot wrap.
- FIFO:
  - Show-ahead: `ev_code`/`ev_release` always reflect the head entry whenever `ev_valid`=1.
  - Pop occurs when `ev_valid`&&`ev_ready`. `ev_ready` while empty is ignored.
  - Push while full and not popping: the event is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both take effect and no overflow occurs.
  - Push and pop in the same cycle while empty: the push is stored, and `ev_valid` rises on the next cycle.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. `ev_level` is a separate counter.
- `overflow`: if a set and `clear_ovf` occur in the same cycle, set wins.
- Reset mid-operation: every state returns to its reset value on the falling edge of `reset`, and queued events are discarded.

## Timing
- Input sampling: `key_valid`/`key_code` are sampled on each rising edge of `clock`.
- Press latency:
  - Edge 1 is the first edge that samples the key.
  - The key must remain stable through edge DEBOUNCE_CYCLES.
  - The FIFO write occurs at that edge, and `ev_valid`=1 immediately after it when the FIFO was empty.
- Release latency: symmetric to press latency, counted from the first edge that samples `key_valid`=0.
- Pop timing: `ev_valid` and the head fields update on the edge where the pop is sampled.
- Throughput: one pop per cycle.
- Output registers: all outputs are registered; there is no combinational path from `ev_ready` to any output.

## Configuration
- `KEYPAD_RELEASE_EVT_EN` defined:
  - Release events are pushed into the FIFO.
  - `ev_release` is driven from the FIFO entry.
- `KEYPAD_RELEASE_EVT_EN` undefined:
  - No release pushes occur.
  - The FSM still walks through DB_RELEASE so that bounce filtering is unchanged.
  - FIFO entries store only the code.
  - `ev_release` is tied to 0.

## Structure
- Package `keypad_pkg`:
  - `kp_state_t` enum {IDLE, DB_PRESS, HELD, DB_RELEASE}.
  - `kp_event_t` struct {release, code[3:0]}.
  - Localparam `KP_CODE_W`=4.
- Sub-module `keypad_event_fifo`, parameterised by depth and entry width:
  - Owns the pointers, `ev_level`, full/empty and the overflow-detect logic.
  - The top level holds the FSM, the debounce counter and the `overflow` register.

## Test plan
- Clean press: hold `key_code`=4'h5 with `key_valid`=1 for 10 cycles, then release for 10 cycles, `ev_ready`=1 throughout.
  - Expect exactly one press event {0,5}, with `ev_valid` rising after edge 4 of the press.
  - With the macro defined, expect one release event {1,5} after edge 4 of the release.
- Bounce rejection: hold `key_valid`=1 for 3 cycles (code A), then 0, then 1.
  - Expect no event and FSM in IDLE.
  - Then hold 4 stable cycles: expect a single press event {0,A}.
- Overflow: `ev_ready`=0, DEPTH=4, macro undefined; enter 5 distinct presses (0,1,2,3,4), each debounced and released.
  - Expect `ev_level`=4 and `overflow`=1.
  - Draining yields codes 0,1,2,3.
  - `clear_ovf` then returns `overflow` to 0.
- Full with simultaneous pop: fill the FIFO to 4, then assert `ev_ready` on the exact cycle a 5th press is pushed.
  - Expect `overflow`=0, `ev_level` staying at 4, and the 5th code at the tail.
- Key roll-over: hold 3 for 6 cycles, then 0 for 2 cycles, then 7 for 6 cycles.
  - With the macro defined, expect events {0,3}, {1,3}, {0,7}.
- Async reset: pull `reset` low mid-DB_PRESS with 2 events queued.
  - Expect `ev_valid`=0, `ev_level`=0 and FSM IDLE immediately.
  - No event is produced for the interrupted press.
